// File: rtl/wash_coin_acceptor_if.sv
// wash_coin_acceptor_if
//   Signal bundle between the coin mechanism / front panel / wash controller side
//   (master) and the coin acceptor (slave).
//   master drives: clk_freq, coin_valid, coin_value, double_sel, start_req,
//                  cancel_req, wash_done
//   slave drives:  coin_in, double_wash, credit, busy, coin_reject,
//                  refund_valid, refund_amount
interface wash_coin_acceptor_if;
  logic [1:0] clk_freq;
  logic       coin_valid;
  logic [1:0] coin_value;
  logic       double_sel;
  logic       start_req;
  logic       cancel_req;
  logic       wash_done;
  logic       coin_in;
  logic       double_wash;
  logic [7:0] credit;
  logic       busy;
  logic       coin_reject;
  logic       refund_valid;
  logic [7:0] refund_amount;

  modport master (
    output clk_freq, coin_valid, coin_value, double_sel, start_req, cancel_req, wash_done,
    input  coin_in, double_wash, credit, busy, coin_reject, refund_valid, refund_amount
  );

  modport slave (
    input  clk_freq, coin_valid, coin_value, double_sel, start_req, cancel_req, wash_done,
    output coin_in, double_wash, credit, busy, coin_reject, refund_valid, refund_amount
  );
endinterface

// File: rtl/wash_coin_acceptor.sv
// wash_coin_acceptor
//   Payment front-end for the washing machine controller. Accumulates coin
//   credit, starts a single or double wash, returns change, refunds on cancel
//   and rejects coins while a wash is starting or running.
//
//   Optional feature: define CREDIT_TIMEOUT_EN to refund idle credit after
//   TIMEOUT_SEC seconds without a coin (second length set by clk_freq).
//
//   Ports:
//     clk   system clock
//     rst   asynchronous reset, active-high
//     bus   wash_coin_acceptor_if.slave
//           in : clk_freq[1:0], coin_valid, coin_value[1:0], double_sel,
//                start_req, cancel_req, wash_done
//           out: coin_in, double_wash, credit[7:0], busy, coin_reject,
//                refund_valid, refund_amount[7:0]
//
//   state  | meaning
//   IDLE   | no credit, waiting for the first coin
//   CREDIT | credit held, accepting coins, start or cancel
//   START  | one cycle: coin_in pulse to controller, change computed
//   BUSY   | wash running, waiting for wash_done rising edge
module wash_coin_acceptor #(
  parameter int unsigned PRICE_SINGLE        = 4,
  parameter int unsigned PRICE_DOUBLE        = 6,
  parameter int unsigned CREDIT_MAX          = 255,
  parameter int unsigned BASE_CYCLES_PER_SEC = 1_000_000,
  parameter int unsigned TIMEOUT_SEC         = 120
) (
  input logic                 clk,
  input logic                 rst,
  wash_coin_acceptor_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CREDIT = 2'd1,
    START  = 2'd2,
    BUSY   = 2'd3
  } state_t;

  localparam logic [7:0] PRICE_S8    = 8'(PRICE_SINGLE);
  localparam logic [7:0] PRICE_D8    = 8'(PRICE_DOUBLE);
  localparam logic [8:0] CREDIT_MAX9 = 9'(CREDIT_MAX);

  state_t     state;
  logic [7:0] credit_r;
  logic [7:0] price_r;
  logic       done_prev;
  logic       coin_in_r;
  logic       double_wash_r;
  logic       busy_r;
  logic       coin_reject_r;
  logic       refund_valid_r;
  logic [7:0] refund_amount_r;

  logic [7:0] coin_units;
  logic [8:0] coin_sum;
  logic       coin_accept;
  logic [7:0] start_price;
  logic       done_rise;
  logic       timeout;

  always_comb begin
    coin_units = 8'd0;
    case (bus.coin_value)
      2'b01:   coin_units = 8'd1;
      2'b10:   coin_units = 8'd2;
      2'b11:   coin_units = 8'd5;
      default: coin_units = 8'd0;
    endcase
  end

  // 9-bit sum so an overflowing coin is rejected instead of wrapping.
  assign coin_sum = {1'b0, credit_r} + {1'b0, coin_units};

  // Cancel wins over a coin in the same cycle, so such a coin is not credited.
  assign coin_accept = bus.coin_valid && (coin_units != 8'd0) && (coin_sum <= CREDIT_MAX9) &&
                       ((state == IDLE) || ((state == CREDIT) && !bus.cancel_req));

  assign start_price = bus.double_sel ? PRICE_D8 : PRICE_S8;
  assign done_rise   = bus.wash_done && !done_prev;

`ifdef CREDIT_TIMEOUT_EN
  localparam logic [23:0] BASE24 = 24'(BASE_CYCLES_PER_SEC);
  localparam logic [15:0] TO16   = 16'(TIMEOUT_SEC);

  logic [23:0] presc;
  logic [15:0] sec_left;
  logic [23:0] presc_load;

  // Reload value picks up clk_freq each time the prescaler restarts.
  assign presc_load = (BASE24 << bus.clk_freq) - 24'd1;
  assign timeout    = (state == CREDIT) && (presc == 24'd0) && (sec_left <= 16'd1);
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      credit_r        <= 8'd0;
      price_r         <= 8'd0;
      done_prev       <= 1'b0;
      coin_in_r       <= 1'b0;
      double_wash_r   <= 1'b0;
      busy_r          <= 1'b0;
      coin_reject_r   <= 1'b0;
      refund_valid_r  <= 1'b0;
      refund_amount_r <= 8'd0;
`ifdef CREDIT_TIMEOUT_EN
      presc           <= 24'd0;
      sec_left        <= 16'd0;
`endif
    end else begin
      done_prev      <= bus.wash_done;
      coin_in_r      <= 1'b0;
      refund_valid_r <= 1'b0;
      // Every presented coin that is not credited goes back to the user.
      coin_reject_r  <= bus.coin_valid && !coin_accept;

`ifdef CREDIT_TIMEOUT_EN
      if (coin_accept) begin
        presc    <= presc_load;
        sec_left <= TO16;
      end else if (state == CREDIT) begin
        if (presc == 24'd0) begin
          presc    <= presc_load;
          sec_left <= sec_left - 16'd1;
        end else begin
          presc <= presc - 24'd1;
        end
      end
`endif

      case (state)
        IDLE: begin
          if (coin_accept) begin
            credit_r <= coin_units;
            state    <= CREDIT;
          end
        end

        CREDIT: begin
          if (bus.cancel_req || timeout) begin
            refund_valid_r  <= 1'b1;
            refund_amount_r <= credit_r;
            credit_r        <= 8'd0;
            state           <= IDLE;
          end else if (bus.coin_valid) begin
            // A coin in the same cycle as start takes the cycle; start is dropped.
            if (coin_accept) begin
              credit_r <= coin_sum[7:0];
            end
          end else if (bus.start_req && (credit_r >= start_price)) begin
            price_r       <= start_price;
            coin_in_r     <= 1'b1;
            double_wash_r <= bus.double_sel;
            busy_r        <= 1'b1;
            state         <= START;
          end
        end

        START: begin
          if (credit_r > price_r) begin
            refund_valid_r  <= 1'b1;
            refund_amount_r <= credit_r - price_r;
          end
          credit_r <= 8'd0;
          state    <= BUSY;
        end

        BUSY: begin
          if (done_rise) begin
            double_wash_r <= 1'b0;
            busy_r        <= 1'b0;
            state         <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.coin_in       = coin_in_r;
  assign bus.double_wash   = double_wash_r;
  assign bus.credit        = credit_r;
  assign bus.busy          = busy_r;
  assign bus.coin_reject   = coin_reject_r;
  assign bus.refund_valid  = refund_valid_r;
  assign bus.refund_amount = refund_amount_r;

endmodule

// File: tb/tb_wash_coin_acceptor.sv
module tb_wash_coin_acceptor;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  wash_coin_acceptor_if bus_if();

  wash_coin_acceptor #(
    .PRICE_SINGLE(4),
    .PRICE_DOUBLE(6),
    .CREDIT_MAX(255),
    .BASE_CYCLES_PER_SEC(10),
    .TIMEOUT_SEC(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic coin(input logic [1:0] code);
    bus_if.coin_valid = 1'b1;
    bus_if.coin_value = code;
    tick();
    bus_if.coin_valid = 1'b0;
    bus_if.coin_value = 2'b00;
  endtask

  task automatic press_start(input logic dsel);
    bus_if.start_req  = 1'b1;
    bus_if.double_sel = dsel;
    tick();
    bus_if.start_req  = 1'b0;
  endtask

  task automatic press_cancel();
    bus_if.cancel_req = 1'b1;
    tick();
    bus_if.cancel_req = 1'b0;
  endtask

  task automatic wash_done_rise();
    bus_if.wash_done = 1'b1;
    tick();
  endtask

  int early_refunds;

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    bus_if.clk_freq   = 2'b00;
    bus_if.coin_valid = 1'b0;
    bus_if.coin_value = 2'b00;
    bus_if.double_sel = 1'b0;
    bus_if.start_req  = 1'b0;
    bus_if.cancel_req = 1'b0;
    bus_if.wash_done  = 1'b0;
    repeat (2) tick();

    check("rst_credit", bus_if.credit, 0);
    check("rst_busy", bus_if.busy, 0);
    check("rst_coin_in", bus_if.coin_in, 0);
    check("rst_double", bus_if.double_wash, 0);
    check("rst_refund_valid", bus_if.refund_valid, 0);
    check("rst_refund_amount", bus_if.refund_amount, 0);
    check("rst_reject", bus_if.coin_reject, 0);
    rst = 1'b0;
    tick();

    // single wash, exact credit
    coin(2'b10);
    check("t1_credit2", bus_if.credit, 2);
    coin(2'b10);
    check("t1_credit4", bus_if.credit, 4);
    press_start(1'b0);
    check("t1_coin_in", bus_if.coin_in, 1);
    check("t1_busy_start", bus_if.busy, 1);
    check("t1_double", bus_if.double_wash, 0);
    tick();
    check("t1_coin_in_pulse", bus_if.coin_in, 0);
    check("t1_credit0", bus_if.credit, 0);
    check("t1_no_refund", bus_if.refund_valid, 0);
    check("t1_busy_wait", bus_if.busy, 1);
    tick();
    check("t1_busy_hold", bus_if.busy, 1);
    wash_done_rise();
    check("t1_busy_end", bus_if.busy, 0);
    bus_if.wash_done = 1'b0;
    tick();

    // double wash with change
    coin(2'b11);
    coin(2'b10);
    check("t2_credit7", bus_if.credit, 7);
    press_start(1'b1);
    check("t2_coin_in", bus_if.coin_in, 1);
    check("t2_double", bus_if.double_wash, 1);
    tick();
    check("t2_refund_valid", bus_if.refund_valid, 1);
    check("t2_refund_amount", bus_if.refund_amount, 1);
    tick();
    check("t2_refund_pulse", bus_if.refund_valid, 0);
    check("t2_refund_held", bus_if.refund_amount, 1);
    repeat (3) tick();
    check("t2_double_held", bus_if.double_wash, 1);
    wash_done_rise();
    check("t2_double_clr", bus_if.double_wash, 0);
    check("t2_busy_end", bus_if.busy, 0);
    bus_if.wash_done = 1'b0;
    tick();

    // insufficient credit, then cancel
    coin(2'b10);
    coin(2'b01);
    press_start(1'b0);
    check("t3_start_ignored", bus_if.coin_in, 0);
    check("t3_credit3", bus_if.credit, 3);
    press_cancel();
    check("t3_refund_valid", bus_if.refund_valid, 1);
    check("t3_refund_amount", bus_if.refund_amount, 3);
    check("t3_credit0", bus_if.credit, 0);
    check("t3_busy", bus_if.busy, 0);

    // coin with start in the same cycle: coin wins
    coin(2'b10);
    coin(2'b01);
    bus_if.coin_valid = 1'b1;
    bus_if.coin_value = 2'b01;
    bus_if.start_req  = 1'b1;
    bus_if.double_sel = 1'b0;
    tick();
    bus_if.coin_valid = 1'b0;
    bus_if.start_req  = 1'b0;
    check("t3_coin_start_credit", bus_if.credit, 4);
    check("t3_coin_start_nostart", bus_if.coin_in, 0);
    press_start(1'b0);
    check("t3_start_after", bus_if.coin_in, 1);
    tick();
    wash_done_rise();
    bus_if.wash_done = 1'b0;
    tick();
    check("t3_wash_end", bus_if.busy, 0);

    // rejections
    coin(2'b00);
    check("t4_invalid_reject", bus_if.coin_reject, 1);
    check("t4_invalid_credit", bus_if.credit, 0);
    for (int i = 0; i < 50; i++) coin(2'b11);
    coin(2'b10);
    coin(2'b01);
    check("t4_credit253", bus_if.credit, 253);
    check("t4_no_reject", bus_if.coin_reject, 0);
    coin(2'b11);
    check("t4_ovf_reject", bus_if.coin_reject, 1);
    check("t4_ovf_credit", bus_if.credit, 253);
    coin(2'b10);
    check("t4_max_accept", bus_if.coin_reject, 0);
    check("t4_credit255", bus_if.credit, 255);
    coin(2'b01);
    check("t4_full_reject", bus_if.coin_reject, 1);
    check("t4_full_credit", bus_if.credit, 255);
    press_cancel();
    check("t4_refund255", bus_if.refund_amount, 255);
    coin(2'b10);
    coin(2'b10);
    press_start(1'b0);
    coin(2'b01);
    check("t4_start_reject", bus_if.coin_reject, 1);
    check("t4_start_credit", bus_if.credit, 0);
    coin(2'b01);
    check("t4_busy_reject", bus_if.coin_reject, 1);
    check("t4_busy_credit", bus_if.credit, 0);
    check("t4_busy_state", bus_if.busy, 1);
    wash_done_rise();
    check("t4_busy_end", bus_if.busy, 0);

    // wash_done already high when entering BUSY is not an edge
    coin(2'b10);
    coin(2'b10);
    press_start(1'b0);
    repeat (3) tick();
    check("t4_level_not_edge", bus_if.busy, 1);
    bus_if.wash_done = 1'b0;
    tick();
    check("t4_still_busy", bus_if.busy, 1);
    wash_done_rise();
    check("t4_edge_end", bus_if.busy, 0);
    bus_if.wash_done = 1'b0;
    tick();

    // cancel with coin, then reset mid-wash
    coin(2'b10);
    bus_if.cancel_req = 1'b1;
    bus_if.coin_valid = 1'b1;
    bus_if.coin_value = 2'b11;
    tick();
    bus_if.cancel_req = 1'b0;
    bus_if.coin_valid = 1'b0;
    check("t5_reject", bus_if.coin_reject, 1);
    check("t5_refund_valid", bus_if.refund_valid, 1);
    check("t5_refund_amount", bus_if.refund_amount, 2);
    check("t5_credit0", bus_if.credit, 0);
    coin(2'b11);
    coin(2'b10);
    press_start(1'b1);
    tick();
    check("t5_in_busy", bus_if.busy, 1);
    check("t5_double_busy", bus_if.double_wash, 1);
    rst = 1'b1;
    #1;
    check("t5_rst_busy", bus_if.busy, 0);
    check("t5_rst_double", bus_if.double_wash, 0);
    check("t5_rst_amount", bus_if.refund_amount, 0);
    check("t5_rst_credit", bus_if.credit, 0);
    check("t5_rst_valid", bus_if.refund_valid, 0);
    tick();
    rst = 1'b0;
    tick();
    check("t5_post_rst_valid", bus_if.refund_valid, 0);

    // idle credit timeout
    bus_if.clk_freq = 2'b01;
    early_refunds = 0;
    coin(2'b01);
    repeat (30) tick();
    coin(2'b01);
    check("t6_credit2", bus_if.credit, 2);
`ifdef CREDIT_TIMEOUT_EN
    for (int i = 0; i < 59; i++) begin
      tick();
      if (bus_if.refund_valid) early_refunds++;
    end
    check("t6_no_early_refund", early_refunds, 0);
    tick();
    check("t6_timeout_valid", bus_if.refund_valid, 1);
    check("t6_timeout_amount", bus_if.refund_amount, 2);
    check("t6_timeout_credit", bus_if.credit, 0);
`else
    for (int i = 0; i < 200; i++) begin
      tick();
      if (bus_if.refund_valid) early_refunds++;
    end
    check("t6_no_refund", early_refunds, 0);
    check("t6_credit_held", bus_if.credit, 2);
    press_cancel();
    check("t6_cancel_amount", bus_if.refund_amount, 2);
`endif
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
